// File: rtl/dmem_mmu_ws.sv
// Data-side MMU: valid/ready request port, single-cycle byte-laned RAM and a wait-stated I/O port.
// Loads are extended to 32 bits; misaligned, unmapped and I/O-timeout accesses answer with a fault code.
module dmem_mmu_ws #(
  parameter logic [31:0] RAM_BASE    = 32'h1000_0000,
  parameter int          RAM_WORDS   = 256,
  parameter logic [31:0] IO_BASE     = 32'h8000_0000,
  parameter int          IO_SPAN_LOG = 8,
  parameter int          IO_TIMEOUT  = 15
) (
  input  logic                   clk,
  input  logic                   resetb,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [31:0]            req_addr,
  input  logic [1:0]             req_size,
  input  logic                   req_signed,
  input  logic [31:0]            req_wdata,
  output logic                   rsp_valid,
  output logic [31:0]            rsp_rdata,
  output logic [1:0]             rsp_fault,
  output logic                   io_en,
  output logic                   io_we,
  output logic [IO_SPAN_LOG-1:0] io_addr,
  output logic [3:0]             io_be,
  output logic [31:0]            io_wdata,
  input  logic [31:0]            io_rdata,
  input  logic                   io_ready
);

  localparam int          AW        = $clog2(RAM_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(4 * RAM_WORDS);
  localparam logic [31:0] IO_BYTES  = 32'd1 << IO_SPAN_LOG;
  localparam logic [7:0]  TOUT_LAST = 8'(IO_TIMEOUT - 1);

  typedef enum logic {IDLE, IO_WAIT} state_t;

  state_t        state_q, state_d;
  logic [7:0]    cnt_q;
  logic [1:0]    off_q, size_q;
  logic          sgn_q;
  logic          accept, misal, ram_hit, io_hit, ram_we;
  logic          io_start, io_done, io_tout;
  logic [3:0]    be;
  logic [31:0]   ram_off, io_off, wdata_m, wdata_sh, ram_rd;
  logic [AW-1:0] ram_idx;
  logic [7:0]    mem [4][RAM_WORDS];

  function automatic logic [31:0] extend(input logic [31:0] word, input logic [1:0] off,
                                         input logic [1:0] size, input logic sgn);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (size)
      2'd0:    return {{24{sgn & sh[7]}}, sh[7:0]};
      2'd1:    return {{16{sgn & sh[15]}}, sh[15:0]};
      default: return sh;
    endcase
  endfunction

  assign req_ready = (state_q == IDLE);
  assign accept    = req_valid && req_ready;

  always_comb begin
    be    = 4'h0;
    misal = 1'b0;
    case (req_size)
      2'd0:    be = 4'b0001 << req_addr[1:0];
      2'd1:    begin be = 4'b0011 << req_addr[1:0]; misal = req_addr[0]; end
      2'd2:    begin be = 4'hF; misal = |req_addr[1:0]; end
      default: misal = 1'b1;
    endcase
  end

  // store data is masked to its size before lane alignment so stray upper bits never reach the bus
  always_comb begin
    case (req_size)
      2'd0:    wdata_m = {24'h0, req_wdata[7:0]};
      2'd1:    wdata_m = {16'h0, req_wdata[15:0]};
      default: wdata_m = req_wdata;
    endcase
  end
  assign wdata_sh = wdata_m << {req_addr[1:0], 3'b000};

  assign ram_off = req_addr - RAM_BASE;
  assign io_off  = req_addr - IO_BASE;
  assign ram_hit = ram_off < RAM_BYTES;
  assign io_hit  = io_off < IO_BYTES;
  assign ram_idx = ram_off[AW+1:2];
  assign ram_we  = accept && req_we && !misal && ram_hit;
  assign ram_rd  = {mem[3][ram_idx], mem[2][ram_idx], mem[1][ram_idx], mem[0][ram_idx]};

  always_ff @(posedge clk) begin
    for (int l = 0; l < 4; l++)
      if (ram_we && be[l]) mem[l][ram_idx] <= wdata_sh[8*l +: 8];
  end

  always_comb begin
    state_d  = state_q;
    io_start = 1'b0;
    io_done  = 1'b0;
    io_tout  = 1'b0;
    case (state_q)
      IDLE:
        if (accept && !misal && !ram_hit && io_hit) begin
          io_start = 1'b1;
          state_d  = IO_WAIT;
        end
      IO_WAIT:
        if (io_ready) begin
          io_done = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == TOUT_LAST) begin
          io_tout = 1'b1;
          state_d = IDLE;
        end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      off_q     <= '0;
      size_q    <= '0;
      sgn_q     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_fault <= '0;
      io_en     <= 1'b0;
      io_we     <= 1'b0;
      io_addr   <= '0;
      io_be     <= '0;
      io_wdata  <= '0;
    end else begin
      state_q   <= state_d;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_fault <= 2'd0;
      if (io_start) cnt_q <= '0;
      else if (state_q == IO_WAIT) cnt_q <= cnt_q + 8'd1;
      if (accept && !io_start) begin
        rsp_valid <= 1'b1;
        if (misal)        rsp_fault <= 2'd1;
        else if (ram_hit) rsp_rdata <= req_we ? 32'h0 : extend(ram_rd, req_addr[1:0], req_size, req_signed);
        else              rsp_fault <= 2'd2;
      end
      if (io_start) begin
        io_en    <= 1'b1;
        io_we    <= req_we;
        io_addr  <= io_off[IO_SPAN_LOG-1:0];
        io_be    <= be;
        io_wdata <= wdata_sh;
        off_q    <= req_addr[1:0];
        size_q   <= req_size;
        sgn_q    <= req_signed;
      end
      if (io_done) begin
        io_en     <= 1'b0;
        io_we     <= 1'b0;
        rsp_valid <= 1'b1;
        rsp_rdata <= io_we ? 32'h0 : extend(io_rdata, off_q, size_q, sgn_q);
      end
      if (io_tout) begin
        io_en     <= 1'b0;
        io_we     <= 1'b0;
        rsp_valid <= 1'b1;
        rsp_fault <= 2'd3;
      end
    end
  end

endmodule
